// File: rtl/as2650_mem_pkg.sv
// Shared defaults and the data-phase encoding for the AS2650 SRAM arbiter.
package as2650_mem_pkg;

   localparam int ADDR_W_DEF = 13;
   localparam int DATA_W_DEF = 8;

   // Which master's read data arrives from the SRAM in the current cycle.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CPU_RD = 2'd1,
      DMA_RD = 2'd2
   } phase_e;

endpackage

// File: rtl/as2650_prot_window.sv
// CPU write-protect window: address comparator, registered violation pulse
// and saturating violation counter.
module as2650_prot_window #(
   parameter int ADDR_W = 13,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prot_en,
   input  logic              cpu_start,
   input  logic              cpu_rw,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [ADDR_W-1:0] prot_lo,
   input  logic [ADDR_W-1:0] prot_hi,
   output logic              blocked,
   output logic              prot_viol,
   output logic [CNT_W-1:0]  prot_cnt
);

   logic             viol_d, viol_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   // An inverted window (lo > hi) can never satisfy both compares.
   always_comb begin
      blocked = prot_en & cpu_rw & (cpu_adr >= prot_lo) & (cpu_adr <= prot_hi);
      viol_d  = cpu_start & blocked;
      cnt_d   = cnt_q;
      if (viol_d && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         viol_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         viol_q <= viol_d;
         cnt_q  <= cnt_d;
      end
   end

   assign prot_viol = viol_q & ~reset;
   assign prot_cnt  = reset ? '0 : cnt_q;

endmodule

// File: rtl/as2650_mem_arbiter.sv
// Single-port SRAM arbiter: the AS2650 CPU owns the first cycle of each memory
// operation, a DMA/loader master fills every other SRAM cycle.
module as2650_mem_arbiter
   import as2650_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_opreq,
   input  logic              cpu_m_io,
   input  logic              cpu_rw,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_dout,
   output logic [DATA_W-1:0] cpu_din,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_adr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_adr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   input  logic              prot_en,
   input  logic [ADDR_W-1:0] prot_lo,
   input  logic [ADDR_W-1:0] prot_hi,
   output logic              prot_viol,
   output logic [CNT_W-1:0]  prot_cnt
);

   phase_e            phase_d, phase_q;
   logic              opreq_d, opreq_q;
   logic [DATA_W-1:0] cpu_din_d, cpu_din_q;
   logic [DATA_W-1:0] dma_rdata_d, dma_rdata_q;
   logic              cpu_start;
   logic              blocked;

   as2650_prot_window #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_prot (
      .clk       (clk),
      .reset     (reset),
      .prot_en   (prot_en),
      .cpu_start (cpu_start),
      .cpu_rw    (cpu_rw),
      .cpu_adr   (cpu_adr),
      .prot_lo   (prot_lo),
      .prot_hi   (prot_hi),
      .blocked   (blocked),
      .prot_viol (prot_viol),
      .prot_cnt  (prot_cnt)
   );

   // DMA handshake: dma_req is held with stable we/adr/wdata until dma_ack;
   // an ack cycle consumes the request, and a read returns dma_rvalid with
   // dma_rdata exactly one cycle after its ack. There is no back-pressure.
   always_comb begin
      sram_en     = 1'b0;
      sram_we     = 1'b0;
      sram_adr    = '0;
      sram_wdata  = '0;
      dma_ack     = 1'b0;
      phase_d     = IDLE;
      opreq_d     = cpu_opreq;
      cpu_start   = cpu_opreq & cpu_m_io & ~opreq_q;

      if (reset) begin
         phase_d = IDLE;
      end else if (cpu_start) begin
         sram_en    = 1'b1;
         sram_we    = cpu_rw & ~blocked;
         sram_adr   = cpu_adr;
         sram_wdata = cpu_dout;
         if (!cpu_rw) phase_d = CPU_RD;
      end else if (dma_req) begin
         sram_en    = 1'b1;
         sram_we    = dma_we;
         sram_adr   = dma_adr;
         sram_wdata = dma_wdata;
         dma_ack    = 1'b1;
         if (!dma_we) phase_d = DMA_RD;
      end

      // Read data is passed through in its phase cycle and held afterwards.
      cpu_din_d   = (phase_q == CPU_RD) ? sram_rdata : cpu_din_q;
      dma_rdata_d = (phase_q == DMA_RD) ? sram_rdata : dma_rdata_q;
      cpu_din     = reset ? '0 : cpu_din_d;
      dma_rdata   = reset ? '0 : dma_rdata_d;
      dma_rvalid  = (phase_q == DMA_RD) & ~reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q     <= IDLE;
         opreq_q     <= 1'b0;
         cpu_din_q   <= '0;
         dma_rdata_q <= '0;
      end else begin
         phase_q     <= phase_d;
         opreq_q     <= opreq_d;
         cpu_din_q   <= cpu_din_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

endmodule

// File: doc/as2650_mem_arbiter.md
# as2650_mem_arbiter

Shares one single-port synchronous SRAM between the AS2650 CPU bus and a secondary DMA/loader master. The CPU owns the first cycle of every memory operation. The DMA port fills the remaining SRAM cycles, including the idle cycles inside a CPU operation. A programmable write-protect window blocks CPU stores into a configured address range and counts violations.

## Interface
Parameters:
- ADDR_W, 13, address width (CPU adr width)
- DATA_W, 8, data width
- CNT_W, 8, violation counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_opreq  in  1  CPU operation request
- cpu_m_io  in  1  1 = memory op, 0 = I/O op (ignored by this block)
- cpu_rw  in  1  1 = write, 0 = read
- cpu_adr  in  ADDR_W  CPU address
- cpu_dout  in  DATA_W  CPU write data
- cpu_din  out  DATA_W  read data to CPU
- dma_req  in  1  DMA request; held until ack
- dma_we  in  1  DMA write
- dma_adr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_ack  out  1  grant pulse; request consumed this cycle
- dma_rdata  out  DATA_W  DMA read data
- dma_rvalid  out  1  dma_rdata valid
- sram_en, sram_we  out  1  SRAM strobe / write enable
- sram_adr  out  ADDR_W; sram_wdata  out  DATA_W
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read strobe
- prot_en  in  1  write-protect enable
- prot_lo, prot_hi  in  ADDR_W  inclusive protected window
- prot_viol  out  1  one-cycle pulse on a blocked CPU write
- prot_cnt  out  CNT_W  saturating violation count

## Operation
- CPU memory op start: cpu_opreq & cpu_m_io high this cycle, and opreq_q (registered cpu_opreq) low.
- The CPU drops opreq for at least one cycle between operations. A held opreq never re-issues an access.
- Arbitration each cycle, priority CPU start > DMA:
  - CPU start: SRAM driven from cpu_adr/cpu_dout, sram_we = cpu_rw & ~blocked. A read marks phase CPU_RD for the next cycle.
  - Otherwise, if dma_req: SRAM driven from DMA, dma_ack = 1. A read marks phase DMA_RD for the next cycle.
  - Otherwise: sram_en = 0.
- States (data phase register): IDLE, CPU_RD, DMA_RD. Each lasts exactly one cycle and returns to IDLE unless a new read is issued that cycle.
- cpu_din:
  - In CPU_RD it is sram_rdata, which is also captured into cpu_din_q.
  - Otherwise it is cpu_din_q, so data stays stable for the rest of the CPU op.
- DMA reads: in DMA_RD, dma_rvalid = 1 and dma_rdata = sram_rdata, also captured into dma_rdata_q. Otherwise dma_rdata = dma_rdata_q.
- Protection:
  - blocked = prot_en & cpu_rw & (prot_lo ≤ cpu_adr ≤ prot_hi), evaluated unsigned.
  - A blocked write still occupies the slot with sram_en = 1 and sram_we = 0, so the DMA is not granted that cycle.
  - prot_viol pulses the next cycle; prot_cnt increments and saturates at 2^CNT_W−1.
  - prot_lo > prot_hi is an empty window and blocks nothing.
  - DMA writes are never blocked.
- I/O ops (cpu_m_io = 0) never touch the SRAM and leave the slot free for the DMA.

## Timing
- SRAM controls are combinational from the current inputs and state; the SRAM samples them at the clock edge.
- CPU read issued in cycle N: cpu_din valid from N+1 until the next CPU read capture.
- DMA: ack in cycle N; for a read, rvalid and rdata in N+1. Back-to-back DMA grants are allowed every cycle.
- Simultaneous CPU start and dma_req: the CPU wins, and the DMA is granted the next cycle if still requesting and no new CPU start.
- Reset (synchronous) forces:
  - state IDLE, opreq_q = 0, cpu_din_q = 0, dma_rdata_q = 0, prot_cnt = 0
  - prot_viol = 0, dma_ack = 0, dma_rvalid = 0, sram_en = 0, sram_we = 0 during the reset cycle
- Reset mid-operation:
  - A pending rvalid is dropped.
  - A CPU opreq still high after reset counts as a new start (opreq_q = 0) and re-issues.
  - A held dma_req is granted once reset is low.

## Structure
- Package as2650_mem_pkg holds ADDR_W/DATA_W defaults and the phase enum (IDLE, CPU_RD, DMA_RD).
- One sub-module: as2650_prot_window, containing the window comparator, the registered violation pulse and the saturating counter.
- Everything else stays in as2650_mem_arbiter.

## Test plan
- **CPU read:** SRAM[0x0123] = 0xA5. Opreq high at adr 0x0123, rw = 0, for 3 cycles. Required: one sram_en, cpu_din = 0xA5 from cycle 2 and held while opreq stays high.
- **Contention:** CPU start and dma_req (read 0x0040 = 0x3C) in the same cycle. Required: CPU served first, dma_ack the next cycle, dma_rvalid with 0x3C one cycle later.
- **DMA fill:** dma_req held for 8 writes while the CPU does I/O ops (m_io = 0). Required: 8 consecutive acks, SRAM contents match.
- **Protection:** prot window 0x1000–0x10FF, CPU write 0x55 to 0x1080. Required: sram_we = 0, prot_viol pulse, prot_cnt = 1, memory unchanged. Write to 0x1100 succeeds. 300 violations leave prot_cnt = 255.
- **Reset mid-DMA-read:** reset asserted in the rvalid cycle. Required: rvalid = 0, all outputs at reset values. A held CPU opreq re-issues after reset is released.
